// File: rtl/fc_score_collector.sv
// Collects one frame of FC class scores and runs an external argmax comparator over it.
// It reports the winning class, or raises a sticky timeout flag if the comparator never finishes.
module fc_score_collector #(
   parameter int DATA_W    = 16,
   parameter int N_CLASSES = 10,
   parameter int TIMEOUT   = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          in_ready,
   output logic [DATA_W*N_CLASSES-1:0]   arr_flat,
   output logic                          cmp_reset,
   output logic                          cmp_enable,
   input  logic                          cmp_done,
   input  logic [3:0]                    cmp_result,
   output logic                          class_valid,
   output logic [3:0]                    class_out,
   output logic                          timeout_err,
   output logic                          busy
);

   localparam int IDX_W = 4;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CLASSES - 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      CINIT  = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   wr_idx;
   logic [CNT_W-1:0]   wait_cnt;

   // Frame FSM; every output is a register updated together with the state transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FILL;
         wr_idx      <= '0;
         wait_cnt    <= '0;
         arr_flat    <= '0;
         in_ready    <= 1'b1;
         busy        <= 1'b0;
         cmp_reset   <= 1'b0;
         cmp_enable  <= 1'b0;
         class_valid <= 1'b0;
         class_out   <= 4'd0;
         timeout_err <= 1'b0;
      end else begin
         cmp_reset   <= 1'b0;
         class_valid <= 1'b0;
         case (state)
            FILL: begin
               if (in_valid) begin
                  for (int k = 0; k < N_CLASSES; k++) begin
                     if (wr_idx == IDX_W'(k)) begin
                        arr_flat[k*DATA_W +: DATA_W] <= in_data;
                     end else begin
                        arr_flat[k*DATA_W +: DATA_W] <= arr_flat[k*DATA_W +: DATA_W];
                     end
                  end
                  if (wr_idx == LAST_IDX) begin
                     wr_idx    <= '0;
                     state     <= CINIT;
                     in_ready  <= 1'b0;
                     busy      <= 1'b1;
                     cmp_reset <= 1'b1;
                  end else begin
                     wr_idx <= wr_idx + 4'd1;
                  end
               end else begin
                  wr_idx <= wr_idx;
               end
            end
            CINIT: begin
               state      <= RUN;
               cmp_enable <= 1'b1;
               wait_cnt   <= '0;
            end
            RUN: begin
               // A done in the same cycle as the last allowed wait still counts as success.
               if (cmp_done) begin
                  class_out   <= cmp_result;
                  cmp_enable  <= 1'b0;
                  class_valid <= 1'b1;
                  wait_cnt    <= '0;
                  state       <= REPORT;
               end else if (wait_cnt == LAST_WAIT) begin
                  timeout_err <= 1'b1;
                  cmp_enable  <= 1'b0;
                  wait_cnt    <= '0;
                  in_ready    <= 1'b1;
                  busy        <= 1'b0;
                  state       <= FILL;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            REPORT: begin
               in_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= FILL;
            end
            default: begin
               cmp_enable <= 1'b0;
               in_ready   <= 1'b1;
               busy       <= 1'b0;
               wr_idx     <= '0;
               wait_cnt   <= '0;
               state      <= FILL;
            end
         endcase
      end
   end

endmodule
